// File: rtl/mdu_pkg.sv
// Shared types and decode helpers for the M-extension multiply/divide sequencer.
package mdu_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [1:0] ALUOP_RTYPE   = 2'b10;

  // Funct3 encoding of the eight M-extension operations
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  // rs1 is treated as two's complement for these ops
  function automatic logic op_is_signed_a(input mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // rs2 is treated as two's complement for these ops
  function automatic logic op_is_signed_b(input mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step, plus the
// shared iteration counter that also paces the multiplier.
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            count_done_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN:0]    shifted;
  logic             fits;
  logic [XLEN-1:0]  rem_sub;

  // Partial remainder shifted left by one with the next dividend bit brought in.
  // The true difference is always below 2^XLEN, so an XLEN-bit subtract suffices.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    fits    = (shifted >= {1'b0, divisor_i});
    rem_sub = shifted[XLEN-1:0] - divisor_i;
  end

  // Load on start, then one restoring step per enabled cycle until XLEN steps are done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else if (start_i) begin
      cnt_q <= '0;
      quo_q <= dividend_i;
      rem_q <= '0;
    end else if (step_i && !count_done_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (fits) begin
        rem_q <= rem_sub;
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign count_done_o = (cnt_q == CNT_W'(XLEN));
  assign quotient_o   = quo_q;
  assign remainder_o  = rem_q;

endmodule

// File: rtl/mdu_seq_controller.sv
// Iterative RV32M/RV64M multiply-divide sequencer with valid/ready on both sides.
// Multiplication is a 1-bit/cycle shift-add kept here; division lives in mdu_div_core.
module mdu_seq_controller
  import mdu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FAST_SPECIAL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            is_mdu,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q;
  mdu_op_e           op_q;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   mag_a_q;
  logic [XLEN-1:0]   mag_b_q;
  logic [XLEN-1:0]   result_q;
  logic [2*XLEN-1:0] prod_q;
  logic              sign_diff_q;
  logic              a_neg_q;
  logic              div0_q;
  logic              ovf_q;

  mdu_op_e           req_op;
  logic              req_a_neg;
  logic              req_b_neg;
  logic [XLEN-1:0]   req_mag_a;
  logic [XLEN-1:0]   req_mag_b;
  logic              accept;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_step;
  logic [2*XLEN-1:0] prod_res;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN-1:0]   div_res;
  logic              quo_op;
  logic              fast_done;

  logic [XLEN-1:0]   core_quo;
  logic [XLEN-1:0]   core_rem;
  logic              core_done;
  logic              core_step;

  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  assign is_mdu    = (ALUOp == ALUOP_RTYPE) && (Funct7 == FUNCT7_MULDIV);
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign accept    = in_valid && in_ready && is_mdu;
  assign core_step = ((state_q == MUL) || (state_q == DIV)) && !core_done;

  // Request decode: operand magnitudes and sign flags shared by both datapaths
  always_comb begin
    req_op    = mdu_op_e'(Funct3);
    req_a_neg = op_is_signed_a(req_op) && rs1[XLEN-1];
    req_b_neg = op_is_signed_b(req_op) && rs2[XLEN-1];
    req_mag_a = neg_if(req_a_neg, rs1);
    req_mag_b = neg_if(req_b_neg, rs2);
  end

  // Shift-add step and result finalisation (sign restore, half select, special cases)
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);
    prod_step = {mul_sum, prod_q[XLEN-1:1]};
    prod_res  = sign_diff_q ? -prod_q : prod_q;
    mul_res   = (op_q == OP_MUL) ? prod_res[XLEN-1:0] : prod_res[2*XLEN-1:XLEN];
    quo_op    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    fast_done = (FAST_SPECIAL != 0) && (div0_q || ovf_q);
    if (div0_q) begin
      div_res = quo_op ? '1 : rs1_q;
    end else if (ovf_q) begin
      div_res = quo_op ? rs1_q : '0;
    end else begin
      div_res = quo_op ? neg_if(sign_diff_q, core_quo) : neg_if(a_neg_q, core_rem);
    end
  end

  mdu_div_core #(
    .XLEN(XLEN)
  ) u_div_core (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (accept),
    .step_i       (core_step),
    .dividend_i   (req_mag_a),
    .divisor_i    (mag_b_q),
    .quotient_o   (core_quo),
    .remainder_o  (core_rem),
    .count_done_o (core_done)
  );

  // Sequencer FSM; special divides still pass one cycle through DIV so their
  // result appears one edge after acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_MUL;
      rs1_q       <= '0;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      result_q    <= '0;
      prod_q      <= '0;
      sign_diff_q <= 1'b0;
      a_neg_q     <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q        <= req_op;
            rs1_q       <= rs1;
            mag_a_q     <= req_mag_a;
            mag_b_q     <= req_mag_b;
            prod_q      <= {{XLEN{1'b0}}, req_mag_b};
            sign_diff_q <= req_a_neg ^ req_b_neg;
            a_neg_q     <= req_a_neg;
            div0_q      <= op_is_div(req_op) && (rs2 == '0);
            ovf_q       <= ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                           (rs1 == MIN_NEG) && (rs2 == '1);
            state_q     <= op_is_div(req_op) ? DIV : MUL;
          end
        end
        MUL: begin
          if (core_done) begin
            result_q <= mul_res;
            state_q  <= DONE;
          end else begin
            prod_q <= prod_step;
          end
        end
        DIV: begin
          if (core_done || fast_done) begin
            result_q <= div_res;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq_controller.sv
// Self-checking bench for mdu_seq_controller (XLEN=32, FAST_SPECIAL=1).
module tb_mdu_seq_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  ALUOp = 2'b10;
  logic [6:0]  Funct7 = 7'b0000001;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        is_mdu;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  mdu_seq_controller #(
    .XLEN(32),
    .FAST_SPECIAL(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUOp     (ALUOp),
    .Funct7    (Funct7),
    .Funct3    (Funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .is_mdu    (is_mdu),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural reference computed with 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = 64'd0;
    case (f3)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // One full transaction: accept, latency, result, optional backpressure and
  // an optional competing request during the releasing handshake
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit overlap);
    int          lat;
    int          exp_lat;
    logic [31:0] exp;
    bit          special;
    exp     = ref_result(f3, a, b);
    special = f3[2] && ((b == 32'd0) ||
              (!f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    exp_lat = special ? 1 : 33;

    lat = 0;
    while (!in_ready && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("ready_before_op", 64'(in_ready), 64'd1);

    Funct3 = f3; rs1 = a; rs2 = b; ALUOp = 2'b10; Funct7 = 7'b0000001;
    out_ready = (hold == 0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
    check("in_ready_after_accept", 64'(in_ready), 64'd0);

    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("result", 64'(result), 64'(exp));

    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_result", 64'(result), 64'(exp));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end

    if (overlap) in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("release_busy", 64'(busy), 64'd0);
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);

    $display("op f3=%0d rs1=%08h rs2=%08h result=%08h expected=%08h latency=%0d hold=%0d overlap=%0d",
             f3, a, b, result, exp, lat, hold, overlap);
  endtask

  initial begin
    int spurious;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Decode: non-M requests are ignored
    Funct7 = 7'b0000000; Funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4;
    #1;
    check("is_mdu_funct7_zero", 64'(is_mdu), 64'd0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ignored_busy", 64'(busy), 64'd0);
    check("ignored_in_ready", 64'(in_ready), 64'd1);
    Funct7 = 7'b0000001; ALUOp = 2'b00;
    #1;
    check("is_mdu_aluop_zero", 64'(is_mdu), 64'd0);
    ALUOp = 2'b10;
    #1;
    check("is_mdu_valid", 64'(is_mdu), 64'd1);

    // Directed cases
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
    do_op(3'd3, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    do_op(3'd5, 32'd100, 32'd7, 0, 1'b0);
    do_op(3'd7, 32'd100, 32'd7, 0, 1'b0);
    do_op(3'd4, 32'd5, 32'd0, 0, 1'b0);
    do_op(3'd6, 32'd5, 32'd0, 0, 1'b0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(3'd0, 32'h1234_5678, 32'h0000_0100, 5, 1'b1);

    // Reset during iteration 10 discards the operation
    Funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) spurious++;
    end
    check("abort_no_out_valid", 64'(spurious), 64'd0);
    $display("abort mid-op: busy=%0d out_valid=%0d result=%08h", busy, out_valid, result);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      do_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
            $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
